axi4l_regbank: RTL and testbench
================================

AXI4L_REGBANK -- requirements
Module: axi4l_regbank

Interface
REQ-001 SHALL provide parameter NREGS, default 4: number of 32-bit registers, range 1..64.
REQ-002 SHALL provide parameter ADDR_W, default 8: AXI byte-address width, with ADDR_W >= clog2(NREGS)+2.
REQ-003 SHALL provide parameter RESET_VAL, default all zeros: NREGS*32-bit vector; register i resets to bits [32i+31:32i].
REQ-004 SHALL provide port aclk, input, 1: clock; all logic is rising-edge.
REQ-005 SHALL provide port areset_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL provide ports awvalid in 1, awready out 1, awaddr in ADDR_W, awprot in 3 (ignored): write-address channel.
REQ-007 SHALL provide ports wvalid in 1, wready out 1, wdata in 32, wstrb in 4: write-data channel.
REQ-008 SHALL provide ports bvalid out 1, bready in 1, bresp out 2: write-response channel.
REQ-009 SHALL provide ports arvalid in 1, arready out 1, araddr in ADDR_W, arprot in 3 (ignored): read-address channel.
REQ-010 SHALL provide ports rvalid out 1, rready in 1, rdata out 32, rresp out 2: read-data channel.
REQ-011 SHALL provide port regs_o, output, NREGS*32: current register contents, register i at [32i+31:32i].
REQ-012 SHALL provide port wr_pulse_o, output, NREGS: one-cycle pulse per register on an accepted write.

Function
REQ-013 SHALL decode index = addr[ADDR_W-1:2]; addr[1:0] ignored; index >= NREGS is out of range.
REQ-014 Write FSM SHALL have states W_IDLE, W_EXEC, W_RESP.
REQ-015 In W_IDLE, awready SHALL equal NOT aw_held and wready SHALL equal NOT w_held; AW and W handshakes are accepted independently, in either order or in the same cycle.
REQ-016 SHALL move to W_EXEC on the edge where both AW and W are held; awready=wready=0 outside W_IDLE.
REQ-017 In W_EXEC, for an in-range index, SHALL update byte k of the register only where wstrb[k]=1, SHALL pulse wr_pulse_o[index] for that cycle, and SHALL move to W_RESP; register value and bvalid=1 are visible after that edge.
REQ-018 An out-of-range write SHALL modify no register, SHALL pulse no wr_pulse_o bit, and SHALL return bresp=2'b10 (SLVERR); in-range writes SHALL return 2'b00.
REQ-019 wstrb=4'b0000 to an in-range index SHALL leave the register unchanged, SHALL still pulse wr_pulse_o, and SHALL return OKAY.
REQ-020 bvalid and bresp SHALL be held stable until bready=1; the FSM SHALL return to W_IDLE and clear the held flags on the bready edge.
REQ-021 Read FSM SHALL have states R_IDLE, R_RESP; arready=1 only in R_IDLE.
REQ-022 On an AR handshake, SHALL capture rdata on the same edge (register content before that edge) and SHALL set rvalid=1; read latency is one cycle.
REQ-023 An out-of-range read SHALL return rdata=0 and rresp=2'b10; in-range reads SHALL return rresp=2'b00.
REQ-024 rdata/rresp SHALL be held stable while rvalid=1 and rready=0; the FSM SHALL return to R_IDLE on the rready edge.
REQ-025 Read and write paths SHALL operate concurrently; a read sampling the same edge as a W_EXEC update SHALL return the old value.
REQ-026 At most one outstanding write and one outstanding read; no other back-pressure source.

Reset
REQ-027 With areset_n=0 at a rising edge: registers=RESET_VAL, FSMs idle, held flags cleared; bvalid=rvalid=0, wr_pulse_o=0, rdata=0, bresp=rresp=2'b00.
REQ-028 Reset mid-transaction SHALL abandon the transaction with no register update; awready=wready=arready=1 in the first cycle after release.

Verification
REQ-029 NREGS=4: AW addr 0x4 and W 0xDEADBEEF, strb 4'hF in the same cycle -> regs_o[63:32]=0xDEADBEEF and wr_pulse_o=4'b0010 one cycle after the handshake; bresp=00.
REQ-030 W 0x11223344 three cycles before AW addr 0x8, strb 4'b0101 over 0xFFFFFFFF -> register 2 = 0xFF22FF44; W held, wready=0 until B completes.
REQ-031 Write and read at 0x10 (index 4, out of range) -> bresp=10, rresp=10, rdata=0, no register change, wr_pulse_o=0.
REQ-032 Read addr 0x0 with rready=0 for 5 cycles while a write to 0x0 completes -> rdata stays at the pre-write value until rready=1.
REQ-033 areset_n=0 for one cycle while in W_EXEC with bready=0 -> no register update, regs_o=RESET_VAL, bvalid=0 after release.

Source files
------------

// File: rtl/axi4l_regbank.sv
// rtl/axi4l_regbank.sv - AXI4-Lite slave register bank with byte-strobed writes
//
// Ports:
//   aclk, areset_n              clock (rising edge), synchronous active-low reset
//   aw*, w*, b*                 AXI4-Lite write address / data / response channels
//   ar*, r*                     AXI4-Lite read address / data channels
//   regs_o                      live register contents, register i at [32i+31:32i]
//   wr_pulse_o                  one-cycle strobe per register on an accepted write
//
// Byte address decode: index = addr[ADDR_W-1:2]; index >= NREGS answers SLVERR.
module axi4l_regbank #(
   parameter int                      NREGS     = 4,
   parameter int                      ADDR_W    = 8,
   parameter logic [NREGS*32-1:0]     RESET_VAL = '0
) (
   input  logic                 aclk,
   input  logic                 areset_n,
   input  logic                 awvalid,
   output logic                 awready,
   input  logic [ADDR_W-1:0]    awaddr,
   input  logic [2:0]           awprot,
   input  logic                 wvalid,
   output logic                 wready,
   input  logic [31:0]          wdata,
   input  logic [3:0]           wstrb,
   output logic                 bvalid,
   input  logic                 bready,
   output logic [1:0]           bresp,
   input  logic                 arvalid,
   output logic                 arready,
   input  logic [ADDR_W-1:0]    araddr,
   input  logic [2:0]           arprot,
   output logic                 rvalid,
   input  logic                 rready,
   output logic [31:0]          rdata,
   output logic [1:0]           rresp,
   output logic [NREGS*32-1:0]  regs_o,
   output logic [NREGS-1:0]     wr_pulse_o
);

   localparam int         IDX_W  = ADDR_W - 2;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_RESP} r_state_t;

   w_state_t              w_state, w_next;
   r_state_t              r_state, r_next;

   logic                  aw_held, w_held;
   logic [IDX_W-1:0]      aw_idx;
   logic [31:0]           w_data;
   logic [3:0]            w_strb;
   logic [NREGS*32-1:0]   regs;

   logic                  aw_hs, w_hs, ar_hs;
   logic                  aw_ok, ar_ok;
   logic [IDX_W-1:0]      ar_idx;
   logic [31:0]           rd_word;

   // Protection bits and the sub-word address bits carry no meaning here.
   logic                  unused_bits;
   assign unused_bits = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign ar_hs  = arvalid && arready;
   assign ar_idx = araddr[ADDR_W-1:2];
   assign regs_o = regs;

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   // ------------------------------------------------------------------
   // Write FSM: AW and W are latched independently; execution starts
   // once both are held (including when the last one arrives this edge).
   // ------------------------------------------------------------------
   always_comb begin
      w_next  = w_state;
      awready = 1'b0;
      wready  = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = !aw_held;
            wready  = !w_held;
            if ((aw_held || awvalid) && (w_held || wvalid))
               w_next = W_EXEC;
         end
         W_EXEC: w_next = W_RESP;
         W_RESP: if (bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Read FSM
   // ------------------------------------------------------------------
   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) r_next = R_RESP;
         end
         R_RESP: if (rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Address decode. Out-of-range indices match no register, so the
   // read word falls to zero and no write pulse can fire.
   // ------------------------------------------------------------------
   always_comb begin
      rd_word = '0;
      ar_ok   = 1'b0;
      aw_ok   = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (ar_idx == IDX_W'(i)) begin
            rd_word = regs[32*i +: 32];
            ar_ok   = 1'b1;
         end
         if (aw_idx == IDX_W'(i))
            aw_ok = 1'b1;
      end
   end

   always_comb begin
      wr_pulse_o = '0;
      if (w_state == W_EXEC) begin
         for (int i = 0; i < NREGS; i++)
            wr_pulse_o[i] = (aw_idx == IDX_W'(i));
      end
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_idx  <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         bvalid  <= 1'b0;
         bresp   <= OKAY;
         regs    <= RESET_VAL;
         rvalid  <= 1'b0;
         rdata   <= '0;
         rresp   <= OKAY;
      end else begin
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= awaddr[ADDR_W-1:2];
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= wdata;
            w_strb <= wstrb;
         end

         if (w_state == W_EXEC) begin
            for (int i = 0; i < NREGS; i++) begin
               if (aw_idx == IDX_W'(i)) begin
                  for (int k = 0; k < 4; k++) begin
                     if (w_strb[k])
                        regs[32*i + 8*k +: 8] <= w_data[8*k +: 8];
                  end
               end
            end
            bvalid <= 1'b1;
            bresp  <= aw_ok ? OKAY : SLVERR;
         end

         if (w_state == W_RESP && bready) begin
            bvalid  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end

         // Read samples the register array before this edge's write lands.
         if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
            rresp  <= ar_ok ? OKAY : SLVERR;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi4l_regbank.sv
// tb/tb_axi4l_regbank.sv - directed self-checking bench for axi4l_regbank
module tb_axi4l_regbank;

   localparam logic [127:0] RV = {32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0001, 32'hA5A5_0000};

   logic          aclk, areset_n;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [7:0]    awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [31:0]   wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic [127:0]  regs_o;
   logic [3:0]    wr_pulse_o;

   logic [127:0]  exp_regs;
   int            total, bad;

   axi4l_regbank #(.NREGS(4), .ADDR_W(8), .RESET_VAL(RV)) dut (
      .aclk(aclk), .areset_n(areset_n),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic drive_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      awvalid = 1'b1; awaddr = a;
      wvalid  = 1'b1; wdata  = d; wstrb = s;
   endtask

   task automatic idle_inputs;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0;
      areset_n = 1'b0;
      awvalid = 1'b0; awaddr = '0; awprot = 3'b000;
      wvalid = 1'b0; wdata = '0; wstrb = '0;
      bready = 1'b0;
      arvalid = 1'b0; araddr = '0; arprot = 3'b000;
      rready = 1'b0;
      exp_regs = RV;

      // Reset state
      tick(); tick();
      chk("rst_regs",  128'(regs_o), exp_regs);
      chk("rst_valid", 128'({bvalid, rvalid}), 128'(2'b00));
      chk("rst_pulse", 128'(wr_pulse_o), 128'(4'b0000));
      chk("rst_rdata", 128'(rdata), 128'(32'h0));
      chk("rst_resp",  128'({bresp, rresp}), 128'(4'b0000));
      areset_n = 1'b1;
      #1;
      chk("rst_ready", 128'({awready, wready, arready}), 128'(3'b111));

      // Same-cycle AW+W to register 1
      drive_write(8'h04, 32'hDEAD_BEEF, 4'hF);
      tick();
      idle_inputs();
      chk("w1_pulse", 128'(wr_pulse_o), 128'(4'b0010));
      chk("w1_rdy_exec", 128'({awready, wready}), 128'(2'b00));
      tick();
      exp_regs[63:32] = 32'hDEAD_BEEF;
      chk("w1_regs", 128'(regs_o), exp_regs);
      chk("w1_b", 128'({bvalid, bresp}), 128'(3'b100));
      chk("w1_pulse_off", 128'(wr_pulse_o), 128'(4'b0000));
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("w1_b_done", 128'({bvalid, awready, wready}), 128'(3'b011));

      // W three cycles ahead of AW, partial strobe on register 2
      wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'b0101;
      tick();
      wvalid = 1'b0;
      chk("w2_wheld", 128'({awready, wready}), 128'(2'b10));
      tick(); tick();
      awvalid = 1'b1; awaddr = 8'h08;
      tick();
      awvalid = 1'b0;
      chk("w2_pulse", 128'(wr_pulse_o), 128'(4'b0100));
      tick();
      exp_regs[95:64] = 32'hFF22_FF44;
      chk("w2_regs", 128'(regs_o), exp_regs);
      chk("w2_b", 128'({bvalid, bresp, wready}), 128'(4'b1000));
      tick();
      chk("w2_b_hold", 128'({bvalid, bresp, wready}), 128'(4'b1000));
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("w2_wready_back", 128'(wready), 128'(1'b1));

      // Zero strobe: pulse and OKAY, no data change
      drive_write(8'h04, 32'h0000_0000, 4'b0000);
      tick();
      idle_inputs();
      chk("w0_pulse", 128'(wr_pulse_o), 128'(4'b0010));
      tick();
      chk("w0_regs", 128'(regs_o), exp_regs);
      chk("w0_b", 128'({bvalid, bresp}), 128'(3'b100));
      bready = 1'b1;
      tick();
      bready = 1'b0;

      // Out-of-range write and read at 0x10
      drive_write(8'h10, 32'h1234_5678, 4'hF);
      arvalid = 1'b1; araddr = 8'h10;
      tick();
      idle_inputs();
      chk("oor_pulse", 128'(wr_pulse_o), 128'(4'b0000));
      chk("oor_r", 128'({rvalid, rresp, rdata}), {93'b0, 3'b110, 32'h0});
      tick();
      chk("oor_b", 128'({bvalid, bresp}), 128'(3'b110));
      chk("oor_regs", 128'(regs_o), exp_regs);
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;
      chk("oor_done", 128'({bvalid, rvalid}), 128'(2'b00));

      // Read register 0 stalled by rready=0 while a write to it completes
      arvalid = 1'b1; araddr = 8'h00;
      tick();
      arvalid = 1'b0;
      chk("rs_first", 128'({rvalid, rresp, rdata}), {93'b0, 3'b100, 32'hA5A5_0000});
      drive_write(8'h00, 32'h0BAD_F00D, 4'hF);
      tick();
      idle_inputs();
      tick();
      exp_regs[31:0] = 32'h0BAD_F00D;
      chk("rs_regs", 128'(regs_o), exp_regs);
      chk("rs_old1", 128'(rdata), 128'(32'hA5A5_0000));
      bready = 1'b1;
      tick();
      bready = 1'b0;
      tick(); tick();
      chk("rs_old2", 128'({rvalid, arready, rdata}), {94'b0, 2'b10, 32'hA5A5_0000});
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("rs_done", 128'({rvalid, arready}), 128'(2'b01));
      arvalid = 1'b1; araddr = 8'h01;
      tick();
      arvalid = 1'b0;
      chk("rs_new", 128'(rdata), 128'(32'h0BAD_F00D));
      rready = 1'b1;
      tick();
      rready = 1'b0;

      // Read on the same edge as a write execute sees the old value
      drive_write(8'h0C, 32'h0000_0077, 4'hF);
      tick();
      idle_inputs();
      arvalid = 1'b1; araddr = 8'h0C;
      tick();
      arvalid = 1'b0;
      exp_regs[127:96] = 32'h0000_0077;
      chk("same_edge_rd", 128'(rdata), 128'(32'h0000_0003));
      chk("same_edge_regs", 128'(regs_o), exp_regs);
      bready = 1'b1; rready = 1'b1;
      tick();
      bready = 1'b0; rready = 1'b0;

      // Reset while in W_EXEC with bready low
      drive_write(8'h04, 32'h5555_5555, 4'hF);
      tick();
      idle_inputs();
      chk("rx_in_exec", 128'(wr_pulse_o), 128'(4'b0010));
      areset_n = 1'b0;
      tick();
      areset_n = 1'b1;
      #1;
      exp_regs = RV;
      chk("rx_regs", 128'(regs_o), exp_regs);
      chk("rx_state", 128'({bvalid, rvalid, wr_pulse_o}), 128'(6'b0));
      chk("rx_ready", 128'({awready, wready, arready}), 128'(3'b111));
      tick();
      chk("rx_bvalid", 128'({bvalid, regs_o}), {1'b0, RV});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
